mmu_tlb: RTL



---
 rtl/mmu_tlb_pkg.sv | 52 +++++
 rtl/mmu_tlb_entry_match.sv | 33 +++
 rtl/mmu_tlb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_tlb_pkg.sv
// rtl/mmu_tlb_pkg.sv - shared constants, entry type and FSM states for the joint TLB
package mmu_tlb_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int INDEX_W     = 3;

    localparam logic [1:0] MMU_NONE = 2'b00;
    localparam logic [1:0] MMU_TLBR = 2'b01;
    localparam logic [1:0] MMU_TLBW = 2'b10;
    localparam logic [1:0] MMU_TLBP = 2'b11;

    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;

    // VA[31:30] of kseg0/kseg1: bypasses the TLB entirely
    localparam logic [1:0] UNMAPPED_SEG = 2'b10;

    // PageMask[28:13] value of a 16 KB page; every other value selects like 4 KB
    localparam logic [15:0] MASK_16K = 16'h0003;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [15:0] mask;
        logic [19:0] pfn0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        CP0_IDLE = 2'd0,
        CP0_ACK  = 2'd1,
        CP0_HOLD = 2'd2
    } cp0_state_t;

    // A 16 KB page keeps VA[13:12] as offset bits in place of the PFN low bits
    function automatic logic [31:0] make_pa(input logic [19:0] pfn,
                                            input logic [31:0] va,
                                            input logic        big);
        if (big) begin
            make_pa = {pfn[19:2], va[13:0]};
        end else begin
            make_pa = {pfn, va[11:0]};
        end
    endfunction

endpackage

// File: rtl/mmu_tlb_entry_match.sv
// rtl/mmu_tlb_entry_match.sv - per-entry VPN2/ASID compare and odd/even page select
//
// Ports:
//   e_vpn2, e_mask, e_g, e_asid : stored entry tag fields
//   vpn2, asid                  : lookup VA[31:13] and ASID
//   va12, va14                  : VA bits used for the odd/even page select
//   hit                         : entry matches the lookup
//   odd                         : lookup falls in the odd page of the pair
module mmu_tlb_entry_match
    import mmu_tlb_pkg::*;
(
    input  logic [18:0] e_vpn2,
    input  logic [15:0] e_mask,
    input  logic        e_g,
    input  logic [7:0]  e_asid,
    input  logic [18:0] vpn2,
    input  logic [7:0]  asid,
    input  logic        va12,
    input  logic        va14,
    output logic        hit,
    output logic        odd
);

    logic vpn_eq;
    logic asid_eq;

    // Masked-off VPN2 bits never take part in the compare
    assign vpn_eq  = ((e_vpn2 ^ vpn2) & ~{3'b000, e_mask}) == 19'd0;
    assign asid_eq = e_g || (e_asid == asid);
    assign hit     = vpn_eq && asid_eq;
    assign odd     = (e_mask == MASK_16K) ? va14 : va12;

endmodule

// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - 8-entry fully associative joint TLB with CP0 TLBR/TLBW/TLBP service
//
// Ports:
//   Clk, Reset_N                         : clock, asynchronous active-low reset
//   EntryHi_I/EntryLo0_I/EntryLo1_I/PageMask_I : CP0 staging registers
//   ASID_I, MMU_Mode_I                   : current ASID, kernel mode
//   MMU_Func_I, MMU_Index_I              : CP0 operation and target entry
//   CP0_RdReq_I, CP0_WrReq_I             : TLBR/TLBP level request, TLBW strobe
//   Trans_Valid_I/VA_I/Store_I           : translation request
//   Trans_Ack_O/PA_O/Exc_O/ExcCode_O     : registered translation result
//   MMU_Req_O, MMU_BadVAddr_O            : fault strobe and faulting VA
//   MMU_EntryHi_O..MMU_PageMask_O        : TLBR read-back
//   MMU_Index_O, MMU_Matched_O           : TLBP result
//   MMU_AckR_O, MMU_AckP_O               : single-cycle TLBR/TLBP done
module mmu_tlb
    import mmu_tlb_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic [31:0]         EntryHi_I,
    input  logic [31:0]         EntryLo0_I,
    input  logic [31:0]         EntryLo1_I,
    input  logic [31:0]         PageMask_I,
    input  logic [7:0]          ASID_I,
    input  logic [1:0]          MMU_Func_I,
    input  logic [INDEX_W-1:0]  MMU_Index_I,
    input  logic                CP0_RdReq_I,
    input  logic                CP0_WrReq_I,
    input  logic                MMU_Mode_I,
    input  logic                Trans_Valid_I,
    input  logic [31:0]         Trans_VA_I,
    input  logic                Trans_Store_I,
    output logic                Trans_Ack_O,
    output logic [31:0]         Trans_PA_O,
    output logic                Trans_Exc_O,
    output logic [6:2]          Trans_ExcCode_O,
    output logic                MMU_Req_O,
    output logic [31:0]         MMU_BadVAddr_O,
    output logic [31:0]         MMU_EntryHi_O,
    output logic [31:0]         MMU_EntryLo0_O,
    output logic [31:0]         MMU_EntryLo1_O,
    output logic [31:0]         MMU_PageMask_O,
    output logic [INDEX_W-1:0]  MMU_Index_O,
    output logic                MMU_AckR_O,
    output logic                MMU_AckP_O,
    output logic                MMU_Matched_O
);

    tlb_entry_t entries [NUM_ENTRIES];
    tlb_entry_t wr_entry;
    tlb_entry_t sel_entry;
    tlb_entry_t rd_entry;

    logic [NUM_ENTRIES-1:0] t_hit;
    logic [NUM_ENTRIES-1:0] t_odd;
    logic [NUM_ENTRIES-1:0] p_hit;
    logic [NUM_ENTRIES-1:0] p_odd_unused;

    logic               t_any;
    logic [INDEX_W-1:0] t_idx;
    logic               p_any;
    logic [INDEX_W-1:0] p_idx;

    logic               sel_odd;
    logic [19:0]        sel_pfn;
    logic               sel_v;
    logic               sel_d;
    logic               t_fault;
    logic [4:0]         t_code;
    logic [31:0]        t_pa;

    logic               tlbw;
    cp0_state_t         state_q;
    cp0_state_t         state_d;
    logic               cp0_capture;
    logic               is_read_q;

    assign tlbw = CP0_WrReq_I && (MMU_Func_I == MMU_TLBW);

    // Translation port and probe port each get their own comparator bank
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
        mmu_tlb_entry_match u_trans (
            .e_vpn2 (entries[gi].vpn2),
            .e_mask (entries[gi].mask),
            .e_g    (entries[gi].g),
            .e_asid (entries[gi].asid),
            .vpn2   (Trans_VA_I[31:13]),
            .asid   (ASID_I),
            .va12   (Trans_VA_I[12]),
            .va14   (Trans_VA_I[14]),
            .hit    (t_hit[gi]),
            .odd    (t_odd[gi])
        );
        mmu_tlb_entry_match u_probe (
            .e_vpn2 (entries[gi].vpn2),
            .e_mask (entries[gi].mask),
            .e_g    (entries[gi].g),
            .e_asid (entries[gi].asid),
            .vpn2   (EntryHi_I[31:13]),
            .asid   (EntryHi_I[7:0]),
            .va12   (1'b0),
            .va14   (1'b0),
            .hit    (p_hit[gi]),
            .odd    (p_odd_unused[gi])
        );
    end

    // Priority encoders: scanning downward leaves the lowest hitting index
    always_comb begin
        t_any = 1'b0;
        t_idx = '0;
        p_any = 1'b0;
        p_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (t_hit[i]) begin
                t_any = 1'b1;
                t_idx = INDEX_W'(i);
            end
            if (p_hit[i]) begin
                p_any = 1'b1;
                p_idx = INDEX_W'(i);
            end
        end
    end

    assign sel_entry = entries[t_idx];
    assign sel_odd   = t_odd[t_idx];
    assign sel_pfn   = sel_odd ? sel_entry.pfn1 : sel_entry.pfn0;
    assign sel_v     = sel_odd ? sel_entry.v1   : sel_entry.v0;
    assign sel_d     = sel_odd ? sel_entry.d1   : sel_entry.d0;

    always_comb begin
        t_fault = 1'b0;
        t_code  = EXCCODE_TLBL;
        t_pa    = {3'b000, Trans_VA_I[28:0]};
        if (Trans_VA_I[31:30] != UNMAPPED_SEG) begin
            t_pa = make_pa(sel_pfn, Trans_VA_I, sel_entry.mask == MASK_16K);
            if (!t_any || !sel_v) begin
                t_fault = 1'b1;
                t_code  = Trans_Store_I ? EXCCODE_TLBS : EXCCODE_TLBL;
            end else if (Trans_Store_I && !sel_d) begin
                t_fault = 1'b1;
                t_code  = EXCCODE_MOD;
            end
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.vpn2 = EntryHi_I[31:13] & ~{3'b000, PageMask_I[28:13]};
        wr_entry.asid = EntryHi_I[7:0];
        wr_entry.g    = EntryLo0_I[0] & EntryLo1_I[0];
        wr_entry.mask = PageMask_I[28:13];
        wr_entry.pfn0 = EntryLo0_I[25:6];
        wr_entry.d0   = EntryLo0_I[2];
        wr_entry.v0   = EntryLo0_I[1];
        wr_entry.pfn1 = EntryLo1_I[25:6];
        wr_entry.d1   = EntryLo1_I[2];
        wr_entry.v1   = EntryLo1_I[1];
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (tlbw) begin
            entries[MMU_Index_I] <= wr_entry;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            Trans_Ack_O     <= 1'b0;
            Trans_PA_O      <= '0;
            Trans_Exc_O     <= 1'b0;
            Trans_ExcCode_O <= '0;
            MMU_Req_O       <= 1'b0;
            MMU_BadVAddr_O  <= '0;
        end else begin
            Trans_Ack_O <= Trans_Valid_I;
            Trans_Exc_O <= Trans_Valid_I && t_fault;
            MMU_Req_O   <= Trans_Valid_I && t_fault;
            if (Trans_Valid_I) begin
                Trans_PA_O      <= t_pa;
                Trans_ExcCode_O <= t_fault ? t_code : 5'd0;
            end
            if (Trans_Valid_I && t_fault) begin
                MMU_BadVAddr_O <= Trans_VA_I;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= CP0_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cp0_capture = 1'b0;
        MMU_AckR_O  = 1'b0;
        MMU_AckP_O  = 1'b0;
        case (state_q)
            CP0_IDLE: begin
                if (CP0_RdReq_I && (MMU_Func_I == MMU_TLBR || MMU_Func_I == MMU_TLBP)) begin
                    cp0_capture = 1'b1;
                    state_d     = CP0_ACK;
                end
            end
            CP0_ACK: begin
                MMU_AckR_O = is_read_q;
                MMU_AckP_O = !is_read_q;
                state_d    = CP0_HOLD;
            end
            CP0_HOLD: begin
                // Waiting here is what keeps a held request from acking twice
                if (!CP0_RdReq_I) begin
                    state_d = CP0_IDLE;
                end
            end
            default: state_d = CP0_IDLE;
        endcase
    end

    assign rd_entry = entries[MMU_Index_I];

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            is_read_q      <= 1'b0;
            MMU_EntryHi_O  <= '0;
            MMU_EntryLo0_O <= '0;
            MMU_EntryLo1_O <= '0;
            MMU_PageMask_O <= '0;
            MMU_Index_O    <= '0;
            MMU_Matched_O  <= 1'b0;
        end else if (cp0_capture) begin
            is_read_q <= (MMU_Func_I == MMU_TLBR);
            if (MMU_Func_I == MMU_TLBR) begin
                MMU_EntryHi_O  <= {rd_entry.vpn2, 5'b00000, rd_entry.asid};
                MMU_EntryLo0_O <= {6'b0, rd_entry.pfn0, 3'b000, rd_entry.d0, rd_entry.v0, rd_entry.g};
                MMU_EntryLo1_O <= {6'b0, rd_entry.pfn1, 3'b000, rd_entry.d1, rd_entry.v1, rd_entry.g};
                MMU_PageMask_O <= {3'b000, rd_entry.mask, 13'b0};
            end else begin
                MMU_Matched_O <= p_any;
                MMU_Index_O   <= p_any ? p_idx : '0;
            end
        end
    end

    // Staging-register bits with no entry storage, and the probe bank's page select
    logic unused_inputs;
    assign unused_inputs = ^{MMU_Mode_I, EntryHi_I[12:8], EntryLo0_I[31:26], EntryLo0_I[5:3],
                             EntryLo1_I[31:26], EntryLo1_I[5:3], PageMask_I[31:29],
                             PageMask_I[12:0], p_odd_unused};

endmodule
